// File: rtl/bcd_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_timer
// Purpose  : Multi-digit BCD countdown timer with load, abort, terminal count
//            and optional auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_down_timer #(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_load_n,
    input  logic [4*DIGITS-1:0] i_data,
    input  logic                i_start,
    input  logic                i_abort,
    output logic [4*DIGITS-1:0] o_dout,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_zero,
    output logic                o_tc
);

    localparam int             C_W   = 4 * DIGITS;
    localparam logic [C_W-1:0] C_ONE = C_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [C_W-1:0] r_count;
    logic [C_W-1:0] w_count_nxt;
    logic [C_W-1:0] r_shadow;
    logic [C_W-1:0] w_shadow_nxt;
    logic [C_W-1:0] w_data_sat;
    logic [C_W-1:0] w_dec;
    logic [DIGITS-1:0] w_borrow;

    assign w_borrow[0] = 1'b1;

    // Per-digit preset saturation and ripple-borrow decrement
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [3:0] w_din;
        logic [3:0] w_cur;

        assign w_din = i_data[4*gi +: 4];
        assign w_cur = r_count[4*gi +: 4];
        assign w_data_sat[4*gi +: 4] = (w_din > 4'd9) ? 4'd9 : w_din;
        assign w_dec[4*gi +: 4] = !w_borrow[gi]      ? w_cur :
                                  (w_cur == 4'd0)    ? 4'd9  :
                                                       w_cur - 4'd1;
        if (gi < DIGITS - 1) begin : g_borrow
            assign w_borrow[gi+1] = w_borrow[gi] && (w_cur == 4'd0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_shadow <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_shadow <= w_shadow_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_shadow_nxt = r_shadow;
        if (i_en && !i_load_n) begin
            w_count_nxt  = w_data_sat;
            w_shadow_nxt = w_data_sat;
            w_state_nxt  = S_IDLE;
        end else if (r_state == S_DONE) begin
            // DONE always lasts one cycle, independent of the enable
            if (AUTO_RELOAD && (r_shadow != '0)) begin
                w_count_nxt = r_shadow;
                w_state_nxt = S_RUN;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else if (i_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!i_abort && i_start) begin
                        w_state_nxt = (r_count != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_count_nxt = w_dec;
                        if (r_count == C_ONE) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign o_dout = r_count;
    assign o_busy = (r_state == S_RUN);
    assign o_done = (r_state == S_DONE);
    assign o_zero = (r_count == '0);
    assign o_tc   = (r_state == S_RUN) && i_en && (r_count == C_ONE);

endmodule
`default_nettype wire
